// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: shared definitions for the FIFO control core and its consumers.
//   DEPTH/PTR_W/CNT_W  - FIFO geometry (8 entries, 3-bit pointers, 4-bit count)
//   state_t            - registered op code decoded by fifo_out
package fifo_ctrl_pkg;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned PTR_W = 3;
  localparam int unsigned CNT_W = 4;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // Codes 011 and 100 are reserved; fifo_out relies on these exact encodings.
  typedef enum logic [2:0] {
    INIT_S   = 3'b000,
    WRITE_S  = 3'b001,
    READ_S   = 3'b010,
    WR_ERR_S = 3'b101,
    RD_ERR_S = 3'b110,
    NOP_S    = 3'b111
  } state_t;

endpackage

// File: rtl/fifo_ctrl_if.sv
// fifo_ctrl_if: request/status bundle between the FIFO control core and the rest
// of the FIFO.
//   wr_en, rd_en       - requests into the core
//   state, data_count  - registered op code and occupancy, decoded by fifo_out
//   head, tail         - read / write pointers into the register file
//   we, re             - combinational register-file / output-register strobes
// master = control core (producer of status), slave = requester / consumer.
interface fifo_ctrl_if;
  import fifo_ctrl_pkg::*;

  logic   wr_en;
  logic   rd_en;
  state_t state;
  cnt_t   data_count;
  ptr_t   head;
  ptr_t   tail;
  logic   we;
  logic   re;

  modport master (
    input  wr_en, rd_en,
    output state, data_count, head, tail, we, re
  );

  modport slave (
    output wr_en, rd_en,
    input  state, data_count, head, tail, we, re
  );
endinterface

// File: rtl/fifo_ns.sv
// fifo_ns: combinational next-state, next-count and next-pointer decode.
//   data_count, head, tail - current registered values
//   wr_en, rd_en           - requests this cycle
//   next_*                 - values to load on the coming edge
//   we, re                 - strobes for the coming edge (reset gating is done by the caller)
module fifo_ns
  import fifo_ctrl_pkg::*;
(
  input  cnt_t   data_count,
  input  ptr_t   head,
  input  ptr_t   tail,
  input  logic   wr_en,
  input  logic   rd_en,
  output state_t next_state,
  output cnt_t   next_count,
  output ptr_t   next_head,
  output ptr_t   next_tail,
  output logic   we,
  output logic   re
);

  logic is_full;
  logic is_empty;

  assign is_full  = (data_count == CNT_W'(DEPTH));
  assign is_empty = (data_count == '0);

  always_comb begin
    next_state = NOP_S;
    next_count = data_count;
    next_head  = head;
    next_tail  = tail;
    we         = 1'b0;
    re         = 1'b0;

    // Priority order matters: a simultaneous request is a no-op even when
    // one side alone would have been an error.
    if (wr_en && rd_en) begin
      next_state = NOP_S;
    end else if (wr_en && is_full) begin
      next_state = WR_ERR_S;
    end else if (wr_en) begin
      next_state = WRITE_S;
      next_count = data_count + CNT_W'(1);
      next_tail  = tail + PTR_W'(1);
      we         = 1'b1;
    end else if (rd_en && is_empty) begin
      next_state = RD_ERR_S;
    end else if (rd_en) begin
      next_state = READ_S;
      next_count = data_count - CNT_W'(1);
      next_head  = head + PTR_W'(1);
      re         = 1'b1;
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: control core of the 8-entry FIFO.
//   clk    - rising-edge clock
//   reset  - synchronous, active-high reset
//   bus    - fifo_ctrl_if.master: wr_en/rd_en in; state, data_count, head, tail,
//            we, re out
// State, count and pointers are registered with one-cycle latency; we/re are
// combinational so the register file captures on the same edge.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  fifo_ctrl_if.master bus
);

  state_t next_state;
  cnt_t   next_count;
  ptr_t   next_head;
  ptr_t   next_tail;
  logic   ns_we;
  logic   ns_re;

  fifo_ns u_ns (
    .data_count (bus.data_count),
    .head       (bus.head),
    .tail       (bus.tail),
    .wr_en      (bus.wr_en),
    .rd_en      (bus.rd_en),
    .next_state (next_state),
    .next_count (next_count),
    .next_head  (next_head),
    .next_tail  (next_tail),
    .we         (ns_we),
    .re         (ns_re)
  );

  // Strobes must not fire on an edge where reset discards the operation.
  always_comb begin
    bus.we = ns_we & ~reset;
    bus.re = ns_re & ~reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.state      <= INIT_S;
      bus.data_count <= '0;
      bus.head       <= '0;
      bus.tail       <= '0;
    end else begin
      bus.state      <= next_state;
      bus.data_count <= next_count;
      bus.head       <= next_head;
      bus.tail       <= next_tail;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed bench for fifo_ctrl with an occupancy/pointer model.
module tb_fifo_ctrl;
  import fifo_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  fifo_ctrl_if bus ();

  fifo_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: occupancy as a plain integer, pointers as integers modulo 8.
  int m_state = 0;
  int m_cnt   = 0;
  int m_head  = 0;
  int m_tail  = 0;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_state = 0; m_cnt = 0; m_head = 0; m_tail = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      if (bus.wr_en && bus.rd_en)  m_state = 7;
      else if (bus.wr_en && m_cnt == 8) m_state = 5;
      else if (bus.wr_en) begin
        m_state = 1; m_cnt = m_cnt + 1; m_tail = (m_tail + 1) % 8;
      end
      else if (bus.rd_en && m_cnt == 0) m_state = 6;
      else if (bus.rd_en) begin
        m_state = 2; m_cnt = m_cnt - 1; m_head = (m_head + 1) % 8;
      end
      else m_state = 7;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_state", int'(bus.state), m_state);
      check("model_count", int'(bus.data_count), m_cnt);
      check("model_head", int'(bus.head), m_head);
      check("model_tail", int'(bus.tail), m_tail);
      check("model_we", int'(bus.we),
            int'(!reset && bus.wr_en && !bus.rd_en && m_cnt < 8));
      check("model_re", int'(bus.re),
            int'(!reset && bus.rd_en && !bus.wr_en && m_cnt > 0));
    end
  end

  task automatic drive(input logic w, input logic r, input logic rst);
    bus.wr_en = w;
    bus.rd_en = r;
    reset     = rst;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held two cycles with a pending write.
    drive(1'b1, 1'b0, 1'b1);
    check("reset_we", int'(bus.we), 0);
    tick(); tick();
    check("reset_state", int'(bus.state), 0);
    check("reset_count", int'(bus.data_count), 0);
    check("reset_head", int'(bus.head), 0);
    check("reset_tail", int'(bus.tail), 0);

    // Fill to 8; tail wraps back to 0.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      check("fill_we", int'(bus.we), 1);
      tick();
      check("fill_state", int'(bus.state), 1);
      check("fill_count", int'(bus.data_count), i);
      check("fill_tail", int'(bus.tail), i % 8);
    end

    // Overflow.
    drive(1'b1, 1'b0, 1'b0);
    check("ovf_we", int'(bus.we), 0);
    tick();
    check("ovf_state", int'(bus.state), 5);
    check("ovf_count", int'(bus.data_count), 8);
    check("ovf_tail", int'(bus.tail), 0);

    // Drain; head wraps back to 0.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      check("drain_re", int'(bus.re), 1);
      tick();
      check("drain_state", int'(bus.state), 2);
      check("drain_count", int'(bus.data_count), 8 - i);
      check("drain_head", int'(bus.head), i % 8);
    end

    // Underflow.
    drive(1'b0, 1'b1, 1'b0);
    check("unf_re", int'(bus.re), 0);
    tick();
    check("unf_state", int'(bus.state), 6);
    check("unf_count", int'(bus.data_count), 0);

    // Three writes, then simultaneous request, then idle.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      tick();
    end
    check("w3_count", int'(bus.data_count), 3);
    check("w3_tail", int'(bus.tail), 3);
    drive(1'b1, 1'b1, 1'b0);
    check("both_we", int'(bus.we), 0);
    check("both_re", int'(bus.re), 0);
    tick();
    check("both_state", int'(bus.state), 7);
    check("both_count", int'(bus.data_count), 3);
    check("both_tail", int'(bus.tail), 3);
    drive(1'b0, 1'b0, 1'b0);
    tick();
    check("idle_state", int'(bus.state), 7);
    check("idle_count", int'(bus.data_count), 3);

    // Up to 5, then reset with a write pending.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      tick();
    end
    check("w5_count", int'(bus.data_count), 5);
    drive(1'b1, 1'b0, 1'b1);
    check("midrst_we", int'(bus.we), 0);
    tick();
    check("midrst_state", int'(bus.state), 0);
    check("midrst_count", int'(bus.data_count), 0);
    check("midrst_tail", int'(bus.tail), 0);

    // INIT does not persist past the first non-reset edge.
    drive(1'b0, 1'b0, 1'b0);
    tick();
    check("post_init_state", int'(bus.state), 7);
    drive(1'b1, 1'b0, 1'b0);
    tick();
    check("post_init_write", int'(bus.state), 1);
    check("post_init_tail", int'(bus.tail), 1);

    drive(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
